ysyx22041405_store_unit: RTL and testbench

YSYX22041405_STORE_UNIT -- requirements
Module: ysyx22041405_store_unit

---
 rtl/ysyx22041405_store_unit.sv | 150 +++++++++++++++
 tb/tb_ysyx22041405_store_unit.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx22041405_store_unit.sv
// Store unit: aligns store data onto byte lanes and issues it as a single
// memory write request, then waits for the write response with a timeout.
module ysyx22041405_store_unit #(
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             st_valid,
  output logic             st_ready,
  input  logic [WIDTH-1:0] st_addr,
  input  logic [WIDTH-1:0] st_data,
  input  logic [7:0]       st_mask,
  output logic             dm_awvalid,
  input  logic             dm_awready,
  output logic [WIDTH-1:0] dm_addr,
  output logic [WIDTH-1:0] dm_wdata,
  output logic [3:0]       dm_wstrb,
  input  logic             dm_bvalid,
  input  logic             dm_bresp,
  output logic             st_done,
  output logic             st_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [7:0] TO_LIMIT = 8'(TIMEOUT);

  state_t           state_r;
  state_t           state_s;
  logic [7:0]       cnt_r;
  logic [7:0]       cnt_s;
  logic             done_s;
  logic             err_s;
  logic             accept_s;
  logic             legal_s;
  logic [3:0]       strb_s;
  logic [WIDTH-1:0] wdata_s;

  assign accept_s = st_valid & st_ready;

  // Size decode: lane replication, strobe and alignment legality.
  always_comb begin
    legal_s = 1'b0;
    strb_s  = 4'b0000;
    wdata_s = st_data;
    case (st_mask)
      8'h01: begin
        legal_s = 1'b1;
        strb_s  = 4'b0001 << st_addr[1:0];
        wdata_s = {4{st_data[7:0]}};
      end
      8'h03: begin
        legal_s = ~st_addr[0];
        strb_s  = 4'b0011 << st_addr[1:0];
        wdata_s = {2{st_data[15:0]}};
      end
      8'h0f: begin
        legal_s = (st_addr[1:0] == 2'b00);
        strb_s  = 4'b1111;
        wdata_s = st_data;
      end
      default: begin
        legal_s = 1'b0;
        strb_s  = 4'b0000;
        wdata_s = st_data;
      end
    endcase
  end

  // Next-state, timeout counter and completion status.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    done_s  = 1'b0;
    err_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          if (legal_s) begin
            state_s = REQ;
          end else begin
            done_s = 1'b1;
            err_s  = 1'b1;
          end
        end else begin
          state_s = IDLE;
        end
      end
      REQ: begin
        if (dm_awready) begin
          state_s = RESP;
          cnt_s   = 8'd0;
        end else begin
          state_s = REQ;
        end
      end
      RESP: begin
        if (dm_bvalid) begin
          state_s = IDLE;
          done_s  = 1'b1;
          err_s   = dm_bresp;
        end else if (cnt_r + 8'd1 == TO_LIMIT) begin
          // Response never came: give up with an error.
          state_s = IDLE;
          cnt_s   = cnt_r + 8'd1;
          done_s  = 1'b1;
          err_s   = 1'b1;
        end else begin
          cnt_s = cnt_r + 8'd1;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State, handshake outputs and request payload registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      cnt_r      <= 8'd0;
      st_ready   <= 1'b1;
      dm_awvalid <= 1'b0;
      st_done    <= 1'b0;
      st_err     <= 1'b0;
      dm_addr    <= '0;
      dm_wdata   <= '0;
      dm_wstrb   <= 4'b0000;
    end else begin
      state_r    <= state_s;
      cnt_r      <= cnt_s;
      st_ready   <= (state_s == IDLE);
      dm_awvalid <= (state_s == REQ);
      st_done    <= done_s;
      st_err     <= err_s;
      if (accept_s && legal_s) begin
        dm_addr  <= {st_addr[WIDTH-1:2], 2'b00};
        dm_wdata <= wdata_s;
        dm_wstrb <= strb_s;
      end
    end
  end

endmodule

// File: tb/tb_ysyx22041405_store_unit.sv
// Directed vector bench for the store unit: table of single requests plus
// hand-written sequences for stalls, timeout, reset and back-to-back issue.
module tb_ysyx22041405_store_unit;

  logic        clk;
  logic        rst_n;
  logic        st_valid;
  logic        st_ready;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic [7:0]  st_mask;
  logic        dm_awvalid;
  logic        dm_awready;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic [3:0]  dm_wstrb;
  logic        dm_bvalid;
  logic        dm_bresp;
  logic        st_done;
  logic        st_err;

  int n_total = 0;
  int n_pass  = 0;

  ysyx22041405_store_unit #(.WIDTH(32), .TIMEOUT(255)) dut (
    .clk(clk), .rst_n(rst_n),
    .st_valid(st_valid), .st_ready(st_ready),
    .st_addr(st_addr), .st_data(st_data), .st_mask(st_mask),
    .dm_awvalid(dm_awvalid), .dm_awready(dm_awready),
    .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_wstrb(dm_wstrb),
    .dm_bvalid(dm_bvalid), .dm_bresp(dm_bresp),
    .st_done(st_done), .st_err(st_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [7:0]  mask;
    logic        bresp;
    logic        legal;
    logic [31:0] exp_addr;
    logic [31:0] exp_wdata;
    logic [3:0]  exp_strb;
    logic        exp_err;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  // Count rising edges until st_done is seen at a falling edge.
  task automatic wait_done(input int start, output int edges);
    edges = start;
    while (!st_done && edges < 600) begin
      @(posedge clk);
      @(negedge clk);
      edges++;
    end
    check("done_seen", 32'(st_done), 32'd1);
  endtask

  task automatic run_vec(input vec_t v);
    int edges;
    @(negedge clk);
    check("ready_pre", 32'(st_ready), 32'd1);
    st_valid = 1'b1; st_addr = v.addr; st_data = v.data; st_mask = v.mask;
    dm_awready = 1'b1; dm_bvalid = 1'b1; dm_bresp = v.bresp;
    @(posedge clk);
    @(negedge clk);
    st_valid = 1'b0;
    check("awvalid", 32'(dm_awvalid), 32'(v.legal));
    if (v.legal) begin
      check("dm_addr", dm_addr, v.exp_addr);
      check("dm_wdata", dm_wdata, v.exp_wdata);
      check("dm_wstrb", 32'(dm_wstrb), 32'(v.exp_strb));
    end
    wait_done(1, edges);
    check("latency", 32'(edges), v.legal ? 32'd3 : 32'd1);
    check("st_err", 32'(st_err), 32'(v.exp_err));
    @(posedge clk);
    @(negedge clk);
    check("done_pulse", 32'(st_done), 32'd0);
    dm_bvalid = 1'b0; dm_bresp = 1'b0;
  endtask

  initial begin
    int edges;
    int done_cnt;
    vecs[0]  = '{32'h8000_0003, 32'h1234_56AB, 8'h01, 1'b0, 1'b1, 32'h8000_0000, 32'hABAB_ABAB, 4'b1000, 1'b0};
    vecs[1]  = '{32'h8000_0000, 32'h0000_00CD, 8'h01, 1'b0, 1'b1, 32'h8000_0000, 32'hCDCD_CDCD, 4'b0001, 1'b0};
    vecs[2]  = '{32'h8000_0001, 32'hFFFF_FF77, 8'h01, 1'b0, 1'b1, 32'h8000_0000, 32'h7777_7777, 4'b0010, 1'b0};
    vecs[3]  = '{32'h8000_0002, 32'hDEAD_BEEF, 8'h03, 1'b0, 1'b1, 32'h8000_0000, 32'hBEEF_BEEF, 4'b1100, 1'b0};
    vecs[4]  = '{32'h1000_0000, 32'h0000_5A5A, 8'h03, 1'b1, 1'b1, 32'h1000_0000, 32'h5A5A_5A5A, 4'b0011, 1'b1};
    vecs[5]  = '{32'h2000_0004, 32'hCAFE_F00D, 8'h0f, 1'b0, 1'b1, 32'h2000_0004, 32'hCAFE_F00D, 4'b1111, 1'b0};
    vecs[6]  = '{32'h2000_0008, 32'h1122_3344, 8'h0f, 1'b1, 1'b1, 32'h2000_0008, 32'h1122_3344, 4'b1111, 1'b1};
    vecs[7]  = '{32'h8000_0001, 32'h1111_1111, 8'h0f, 1'b0, 1'b0, 32'h0, 32'h0, 4'b0000, 1'b1};
    vecs[8]  = '{32'h8000_0000, 32'h2222_2222, 8'h07, 1'b0, 1'b0, 32'h0, 32'h0, 4'b0000, 1'b1};
    vecs[9]  = '{32'h8000_0001, 32'h3333_3333, 8'h03, 1'b0, 1'b0, 32'h0, 32'h0, 4'b0000, 1'b1};
    vecs[10] = '{32'h8000_0002, 32'h4444_4444, 8'h0f, 1'b0, 1'b0, 32'h0, 32'h0, 4'b0000, 1'b1};
    vecs[11] = '{32'h8000_0000, 32'h5555_5555, 8'h00, 1'b0, 1'b0, 32'h0, 32'h0, 4'b0000, 1'b1};

    rst_n = 1'b0; st_valid = 1'b0; st_addr = 32'h0; st_data = 32'h0; st_mask = 8'h00;
    dm_awready = 1'b0; dm_bvalid = 1'b0; dm_bresp = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_ready", 32'(st_ready), 32'd1);
    check("rst_awvalid", 32'(dm_awvalid), 32'd0);
    check("rst_done", 32'(st_done), 32'd0);
    check("rst_err", 32'(st_err), 32'd0);
    check("rst_addr", dm_addr, 32'd0);
    check("rst_wdata", dm_wdata, 32'd0);
    check("rst_strb", 32'(dm_wstrb), 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 12; i++) run_vec(vecs[i]);

    // Stalled awready: payload must hold for four REQ cycles.
    @(negedge clk);
    st_valid = 1'b1; st_addr = 32'h8000_0002; st_data = 32'hDEAD_BEEF; st_mask = 8'h03;
    dm_awready = 1'b0; dm_bvalid = 1'b0; dm_bresp = 1'b0;
    @(posedge clk);
    @(negedge clk);
    st_valid = 1'b0; st_data = 32'h0; st_addr = 32'h0;
    edges = 1;
    for (int i = 0; i < 4; i++) begin
      check("stall_awvalid", 32'(dm_awvalid), 32'd1);
      check("stall_addr", dm_addr, 32'h8000_0000);
      check("stall_wdata", dm_wdata, 32'hBEEF_BEEF);
      check("stall_strb", 32'(dm_wstrb), 32'(4'b1100));
      check("stall_nodone", 32'(st_done), 32'd0);
      @(posedge clk);
      @(negedge clk);
      edges++;
    end
    check("stall_awvalid_last", 32'(dm_awvalid), 32'd1);
    dm_awready = 1'b1; dm_bvalid = 1'b1;
    wait_done(edges, edges);
    check("stall_latency", 32'(edges), 32'd7);
    check("stall_err", 32'(st_err), 32'd0);
    @(negedge clk);
    dm_bvalid = 1'b0;

    // Timeout: no response, then a stray bvalid in IDLE.
    @(negedge clk);
    st_valid = 1'b1; st_addr = 32'h8000_0010; st_data = 32'h0000_0055; st_mask = 8'h0f;
    dm_awready = 1'b1; dm_bvalid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    st_valid = 1'b0;
    wait_done(1, edges);
    check("to_latency", 32'(edges), 32'd257);
    check("to_err", 32'(st_err), 32'd1);
    @(negedge clk);
    dm_bvalid = 1'b1;
    done_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (st_done) done_cnt++;
    end
    check("stray_bvalid_done", 32'(done_cnt), 32'd0);
    check("stray_ready", 32'(st_ready), 32'd1);
    dm_bvalid = 1'b0;

    // Reset while in REQ drops awvalid at once.
    @(negedge clk);
    st_valid = 1'b1; st_addr = 32'h8000_0020; st_mask = 8'h0f; dm_awready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    st_valid = 1'b0;
    check("rq_awvalid", 32'(dm_awvalid), 32'd1);
    #2 rst_n = 1'b0;
    #1 check("rq_rst_awvalid", 32'(dm_awvalid), 32'd0);
    check("rq_rst_ready", 32'(st_ready), 32'd1);
    check("rq_rst_addr", dm_addr, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Reset while in RESP: transaction abandoned, no st_done.
    @(negedge clk);
    st_valid = 1'b1; st_addr = 32'h8000_0024; st_mask = 8'h0f; dm_awready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    st_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("rs_in_resp_awvalid", 32'(dm_awvalid), 32'd0);
    check("rs_in_resp_ready", 32'(st_ready), 32'd0);
    #2 rst_n = 1'b0;
    #1 check("rs_rst_ready", 32'(st_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1; dm_bvalid = 1'b1;
    done_cnt = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (st_done) done_cnt++;
    end
    check("rs_no_done", 32'(done_cnt), 32'd0);
    dm_bvalid = 1'b0;

    // Back-to-back: second request accepted in the st_done cycle.
    @(negedge clk);
    st_valid = 1'b1; st_addr = 32'h8000_0001; st_data = 32'h0000_0011; st_mask = 8'h01;
    dm_awready = 1'b1; dm_bvalid = 1'b1; dm_bresp = 1'b0;
    @(posedge clk);
    @(negedge clk);
    st_valid = 1'b0;
    wait_done(1, edges);
    check("b2b_first_latency", 32'(edges), 32'd3);
    check("b2b_first_err", 32'(st_err), 32'd0);
    check("b2b_ready_in_done", 32'(st_ready), 32'd1);
    st_valid = 1'b1; st_addr = 32'h8000_0040; st_data = 32'h89AB_CDEF; st_mask = 8'h0f; dm_bresp = 1'b1;
    @(posedge clk);
    @(negedge clk);
    st_valid = 1'b0;
    check("b2b_awvalid", 32'(dm_awvalid), 32'd1);
    check("b2b_addr", dm_addr, 32'h8000_0040);
    check("b2b_wdata", dm_wdata, 32'h89AB_CDEF);
    check("b2b_strb", 32'(dm_wstrb), 32'(4'b1111));
    wait_done(1, edges);
    check("b2b_second_latency", 32'(edges), 32'd3);
    check("b2b_second_err", 32'(st_err), 32'd1);
    @(negedge clk);
    check("b2b_done_pulse", 32'(st_done), 32'd0);
    dm_bvalid = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
